countdown_timer: RTL

//   Loadable SS.hh countdown timer: four cascaded BCD down-digits decremented at a prescaled

---
 rtl/timer_pkg.sv | 28 ++
 rtl/mod_down_counter.sv | 45 ++++
 rtl/countdown_timer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared state type, digit moduli and load saturation helper
// for the SS.hh BCD countdown timer ({sec_tens, sec_units, tenths, hundredths}).
package timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;

    localparam int BCD_WID = 4;

    // Index 0 is the most significant digit (sec_tens).
    localparam int DIGIT_MOD [4] = '{6, 10, 10, 10};

    // Clamp each digit of a loaded value to its modulus minus one.
    function automatic logic [4*BCD_WID-1:0] sat_bcd(
        input logic [4*BCD_WID-1:0] v
    );
        logic [4*BCD_WID-1:0] r;
        logic [BCD_WID-1:0]   lim;
        logic [BCD_WID-1:0]   dig;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            lim = BCD_WID'(DIGIT_MOD[3-i] - 1);
            dig = v[i*BCD_WID +: BCD_WID];
            r[i*BCD_WID +: BCD_WID] = (dig > lim) ? lim : dig;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_down_counter.sv
// mod_down_counter: loadable modulo-N down counter for one BCD digit.
// Wraps 0 -> MOD_VALUE-1 and raises a combinational borrow on that wrap.
module mod_down_counter #(
    parameter int MOD_VALUE = 10,
    parameter int WID       = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [WID-1:0] load_value,
    input  logic           decrement,
    output logic           borrow,
    output logic [WID-1:0] count
);

    logic [WID-1:0] count_q;
    logic [WID-1:0] count_d;

    // Next digit value and borrow into the next-higher digit.
    always_comb begin
        borrow  = decrement && (count_q == '0);
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (decrement) begin
            if (count_q == '0) begin
                count_d = WID'(MOD_VALUE - 1);
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: SS.hh BCD countdown with prescaled tick, start/stop/load
// control, registered running/expired decodes and a one-cycle done pulse.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int TICK_WID = $clog2(TICK_DIV)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] count,
    output logic        running,
    output logic        expired,
    output logic        done
);

    timer_state_t        state_q;
    timer_state_t        state_d;
    logic [TICK_WID-1:0] presc_q;
    logic [TICK_WID-1:0] presc_d;
    logic                done_q;
    logic                done_d;

    logic        tick;
    logic        dec_en;
    logic        load_acc;
    logic        cnt_zero;
    logic        cnt_one;
    logic [15:0] count_w;
    logic [15:0] load_sat;
    logic [3:0]  dec;
    logic [3:0]  borrow;
    logic        borrow_unused;

    assign tick     = (state_q == RUN) &&
                      (presc_q == TICK_WID'(TICK_DIV - 1));
    assign load_acc = load && (state_q != RUN);
    assign load_sat = sat_bcd(load_value);
    assign cnt_zero = (count_w == 16'h0000);
    assign cnt_one  = (count_w == 16'h0001);

    // Hundredths digit takes the tick; each higher digit takes the borrow below.
    assign dec           = {borrow[2:0], dec_en};
    assign borrow_unused = borrow[3];

    for (genvar i = 0; i < 4; i++) begin : g_digit
        mod_down_counter #(
            .MOD_VALUE (DIGIT_MOD[3-i]),
            .WID       (BCD_WID)
        ) u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (load_acc),
            .load_value (load_sat[i*BCD_WID +: BCD_WID]),
            .decrement  (dec[i]),
            .borrow     (borrow[i]),
            .count      (count_w[i*BCD_WID +: BCD_WID])
        );
    end

    // Control FSM: load beats stop beats start; decrement only on an unstopped tick.
    always_comb begin
        state_d = state_q;
        dec_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load || stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = cnt_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = PAUSE;
                end else if (tick && !cnt_zero) begin
                    dec_en = 1'b1;
                    if (cnt_one) begin
                        state_d = DONE;
                    end
                end
            end
            PAUSE: begin
                if (load) begin
                    state_d = IDLE;
                end else if (stop) begin
                    state_d = PAUSE;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (load) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler runs only while staying in RUN; any entry to RUN restarts it.
    always_comb begin
        presc_d = '0;
        done_d  = (state_d == DONE) && (state_q != DONE);
        if ((state_q == RUN) && (state_d == RUN) && !tick) begin
            presc_d = presc_q + 1'b1;
        end
    end

    // State, prescaler and done pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    assign count   = count_w;
    assign running = (state_q == RUN);
    assign expired = (state_q == DONE);
    assign done    = done_q;

endmodule
